// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the multi-channel reset sequencer.
//   seq_state_t  : sequencer state encoding (WAIT_LOCK, HOLD, STAGGER, RUN)
//   clog2_min1() : ceiling log2 with a minimum result of 1, used to size the
//                  channel index register so that N_CH = 1 still yields a
//                  legal one-bit vector.
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        STAGGER   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << width) < value) begin
                width = width + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/rst_seq_gen_if.sv
// -----------------------------------------------------------------------------
// rst_seq_gen_if
// Bundles the lock/request inputs and reset outputs of rst_seq_gen.
//   LOCK        : PLL/MMCM lock, asynchronous to the sequencer clock
//   SW_RST_REQ  : single-cycle software re-sequence request
//   RST_OUT     : per-channel active-high reset, N_CH bits
//   SEQ_DONE    : high once every channel has been released
// Modports:
//   master : drives LOCK and SW_RST_REQ, observes the reset outputs
//   slave  : the sequencer side
// -----------------------------------------------------------------------------
interface rst_seq_gen_if #(
    parameter int N_CH = 4
) ();

    logic            LOCK;
    logic            SW_RST_REQ;
    logic [N_CH-1:0] RST_OUT;
    logic            SEQ_DONE;

    modport master (
        output LOCK,
        output SW_RST_REQ,
        input  RST_OUT,
        input  SEQ_DONE
    );

    modport slave (
        input  LOCK,
        input  SW_RST_REQ,
        output RST_OUT,
        output SEQ_DONE
    );

endinterface

// File: rtl/rst_lock_filter.sv
// -----------------------------------------------------------------------------
// rst_lock_filter
// Two-flop synchroniser followed by a consecutive-high filter on LOCK.
// Ports:
//   CLK     in   system clock
//   RST     in   synchronous active-high reset
//   LOCK    in   raw lock, asynchronous to CLK
//   lock_ok out  high while the synchronised lock has been high for at least
//                LOCK_FILT consecutive samples; drops on the first low sample
// -----------------------------------------------------------------------------
module rst_lock_filter #(
    parameter int LOCK_FILT = 16,
    parameter int CNT_W     = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic LOCK,
    output logic lock_ok
);

    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync_meta;
    logic             sync_lock;
    logic [CNT_W-1:0] filt_cnt;

    // filt_cnt holds the number of high samples that preceded the current
    // synchronised sample, so lock_ok can include the current sample without
    // an extra register stage. It saturates at LOCK_FILT-1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_meta <= 1'b0;
            sync_lock <= 1'b0;
            filt_cnt  <= '0;
        end else begin
            sync_meta <= LOCK;
            sync_lock <= sync_meta;
            if (!sync_lock) begin
                filt_cnt <= '0;
            end else if (filt_cnt < FILT_LAST) begin
                filt_cnt <= filt_cnt + CNT_ONE;
            end
        end
    end

    assign lock_ok = sync_lock && (filt_cnt >= FILT_LAST);

endmodule

// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
// Multi-channel reset sequencer. Holds all reset channels asserted until the
// clock source reports a qualified lock, waits HOLD_CYCLES, then releases the
// channels in index order, STAGGER_CYCLES apart (all at once when zero).
// Loss of lock restarts from lock qualification; a software request restarts
// from the hold phase.
// Ports:
//   CLK   in   system clock, rising edge
//   RST   in   synchronous active-high reset
//   bus   slave modport of rst_seq_gen_if (LOCK, SW_RST_REQ in;
//         RST_OUT[N_CH], SEQ_DONE out, both registered)
// -----------------------------------------------------------------------------
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int HOLD_CYCLES    = 10000,
    parameter int STAGGER_CYCLES = 1000,
    parameter int LOCK_FILT      = 16,
    parameter int CNT_W          = 16
) (
    input  logic         CLK,
    input  logic         RST,
    rst_seq_gen_if.slave bus
);

    localparam int               IDX_W     = clog2_min1(N_CH);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((STAGGER_CYCLES > 0) ? (STAGGER_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_CH - 1);
    localparam logic [N_CH-1:0]  ALL_ON    = {N_CH{1'b1}};
    // A single release edge covers every channel when there is nothing to stagger.
    localparam bit               ONE_SHOT  = (N_CH == 1) || (STAGGER_CYCLES == 0);

    logic             lock_ok;

    seq_state_t       state;
    seq_state_t       state_n;
    logic [CNT_W-1:0] seq_cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [IDX_W-1:0] ch_idx;
    logic [IDX_W-1:0] idx_n;
    logic [N_CH-1:0]  rst_out_q;
    logic [N_CH-1:0]  rst_out_n;
    logic             seq_done_q;
    logic             done_n;

    rst_lock_filter #(
        .LOCK_FILT (LOCK_FILT),
        .CNT_W     (CNT_W)
    ) u_lock_filter (
        .CLK     (CLK),
        .RST     (RST),
        .LOCK    (bus.LOCK),
        .lock_ok (lock_ok)
    );

    // State, shared hold/stagger counter, channel index and the registered
    // outputs all update together so outputs never see input glitches.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= WAIT_LOCK;
            seq_cnt    <= '0;
            ch_idx     <= '0;
            rst_out_q  <= ALL_ON;
            seq_done_q <= 1'b0;
        end else begin
            state      <= state_n;
            seq_cnt    <= cnt_n;
            ch_idx     <= idx_n;
            rst_out_q  <= rst_out_n;
            seq_done_q <= done_n;
        end
    end

    // Lock loss outranks a software request; both force every channel back
    // into reset at once. The counter doubles as hold timer and stagger timer
    // and restarts from zero on every phase change.
    always_comb begin
        state_n   = state;
        cnt_n     = (seq_cnt == CNT_MAX) ? seq_cnt : seq_cnt + CNT_ONE;
        idx_n     = ch_idx;
        rst_out_n = rst_out_q;
        done_n    = seq_done_q;

        if (state == WAIT_LOCK) begin
            cnt_n     = '0;
            rst_out_n = ALL_ON;
            done_n    = 1'b0;
            if (lock_ok) begin
                state_n = HOLD;
            end
        end else if (!lock_ok) begin
            state_n   = WAIT_LOCK;
            cnt_n     = '0;
            rst_out_n = ALL_ON;
            done_n    = 1'b0;
        end else if (bus.SW_RST_REQ) begin
            state_n   = HOLD;
            cnt_n     = '0;
            rst_out_n = ALL_ON;
            done_n    = 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (seq_cnt == HOLD_LAST) begin
                        cnt_n = '0;
                        if (ONE_SHOT) begin
                            rst_out_n = '0;
                            done_n    = 1'b1;
                            state_n   = RUN;
                        end else begin
                            rst_out_n[0] = 1'b0;
                            idx_n        = IDX_ONE;
                            state_n      = STAGGER;
                        end
                    end
                end
                STAGGER: begin
                    if (seq_cnt == STAG_LAST) begin
                        cnt_n = '0;
                        for (int k = 0; k < N_CH; k++) begin
                            if (ch_idx == IDX_W'(k)) begin
                                rst_out_n[k] = 1'b0;
                            end
                        end
                        if (ch_idx == LAST_IDX) begin
                            done_n  = 1'b1;
                            state_n = RUN;
                        end else begin
                            idx_n = ch_idx + IDX_ONE;
                        end
                    end
                end
                RUN: begin
                    cnt_n     = seq_cnt;
                    rst_out_n = '0;
                    done_n    = 1'b1;
                end
                default: begin
                    state_n = WAIT_LOCK;
                end
            endcase
        end
    end

    assign bus.RST_OUT  = rst_out_q;
    assign bus.SEQ_DONE = seq_done_q;

endmodule
